grey_clk_div: RTL and testbench

- Programmable clock-enable divider driving an up/down Gray-code counter.
- A binary prescaler counts clk cycles and produces a one-cycle tick every (div_reg+1) enabled cycles; each tick steps a GREY_W-bit Gray counter by one code.
- Parametrised successor of the fixed divide-by-16, 6-bit Gray divider. Adds run-time divisor, enable, direction, clear, and tick/wrap status outputs.
- Sits between the chip clock and user logic or pads that need a slow, glitch-safe (single-bit-change) count.

---
 rtl/grey_clk_div_pkg.sv | 45 ++++
 rtl/grey_clk_div_if.sv | 45 ++++
 rtl/grey_clk_div_step.sv | 75 +++++++
 rtl/grey_clk_div.sv | 99 +++++++++
 tb/tb_grey_clk_div.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/grey_clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grey_clk_div_pkg
// Description : Shared constants and Gray-code helpers for the grey_clk_div
//               programmable clock-enable divider.
//               - bin2grey    : binary to Gray (x ^ (x >> 1))
//               - grey2bin    : Gray to binary (prefix XOR from the MSB down)
//               - f_grey_next : Gray successor/predecessor within w bits
//               The functions work on a fixed c_FN_W-bit container, so any
//               GREY_W up to c_FN_W can use them after a size cast.
// Revision    : 1.0 - initial release
// ============================================================================
package grey_clk_div_pkg;

    // Below two bits a Gray code is just a binary toggle.
    localparam int c_GREY_W_MIN = 2;
    localparam int c_FN_W       = 32;

    function automatic logic [c_FN_W-1:0] bin2grey(input logic [c_FN_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [c_FN_W-1:0] grey2bin(input logic [c_FN_W-1:0] g);
        logic [c_FN_W-1:0] b;
        b[c_FN_W-1] = g[c_FN_W-1];
        for (int i = c_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next Gray code (up=1) or previous one (up=0), wrapping modulo 2^w.
    function automatic logic [c_FN_W-1:0] f_grey_next(input logic [c_FN_W-1:0] g,
                                                      input logic              up,
                                                      input int                w);
        logic [c_FN_W-1:0] mask;
        logic [c_FN_W-1:0] b;
        mask = (w >= c_FN_W) ? '1 : ((32'd1 << w) - 32'd1);
        b    = grey2bin(g & mask);
        b    = up ? (b + 32'd1) : (b - 32'd1);
        return bin2grey(b & mask);
    endfunction

endpackage : grey_clk_div_pkg
`default_nettype wire

// File: rtl/grey_clk_div_if.sv
`default_nettype none
// ============================================================================
// Module      : grey_clk_div_if
// Description : Control/status bundle of grey_clk_div.
//               Inputs to the divider : en, div_ld, div_val, dir, clr
//               Outputs of the divider: tick, grey, wrap
//               (+ bin when GREY_CLK_DIV_BIN_OUT_EN is defined)
//               master = the controlling side, slave = the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface grey_clk_div_if #(
    parameter int DIV_W  = 8,
    parameter int GREY_W = 6
) ();

    logic              en;
    logic              div_ld;
    logic [DIV_W-1:0]  div_val;
    logic              dir;
    logic              clr;
    logic              tick;
    logic [GREY_W-1:0] grey;
    logic              wrap;
`ifdef GREY_CLK_DIV_BIN_OUT_EN
    logic [GREY_W-1:0] bin;
`endif

    modport master (
        output en, div_ld, div_val, dir, clr,
`ifdef GREY_CLK_DIV_BIN_OUT_EN
        input  bin,
`endif
        input  tick, grey, wrap
    );

    modport slave (
        input  en, div_ld, div_val, dir, clr,
`ifdef GREY_CLK_DIV_BIN_OUT_EN
        output bin,
`endif
        output tick, grey, wrap
    );

endinterface : grey_clk_div_if
`default_nettype wire

// File: rtl/grey_clk_div_step.sv
`default_nettype none
// ============================================================================
// Module      : grey_step_ctr
// Description : GREY_W-bit up/down Gray register.
//               clk, rst (sync, active-low), i_step (advance one code),
//               i_dir (1 = up), i_clr (sync clear, beats i_step),
//               o_grey (registered code), o_wrap (one-cycle wrap pulse),
//               o_bin (registered binary, only with GREY_CLK_DIV_BIN_OUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module grey_step_ctr
    import grey_clk_div_pkg::*;
#(
    parameter int GREY_W = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_step,
    input  wire logic              i_dir,
    input  wire logic              i_clr,
`ifdef GREY_CLK_DIV_BIN_OUT_EN
    output logic [GREY_W-1:0]      o_bin,
`endif
    output logic [GREY_W-1:0]      o_grey,
    output logic                   o_wrap
);

    // Gray image of the all-ones binary value: only the MSB set. Wrap can
    // therefore be detected from the Gray register alone, no binary copy.
    localparam logic [GREY_W-1:0] c_GREY_TOP = {1'b1, {(GREY_W-1){1'b0}}};

    logic [GREY_W-1:0] r_grey;
    logic              r_wrap;
    logic              w_wrap_next;

    assign w_wrap_next = i_dir ? (r_grey == c_GREY_TOP) : (r_grey == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grey <= '0;
            r_wrap <= 1'b0;
        end else if (i_clr) begin
            r_grey <= '0;
            r_wrap <= 1'b0;
        end else if (i_step) begin
            r_grey <= GREY_W'(f_grey_next(c_FN_W'(r_grey), i_dir, GREY_W));
            r_wrap <= w_wrap_next;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_grey = r_grey;
    assign o_wrap = r_wrap;

`ifdef GREY_CLK_DIV_BIN_OUT_EN
    // Binary shadow stepped in lock-step with r_grey, so it always equals
    // grey2bin(r_grey) without a combinational prefix-XOR chain on the output.
    logic [GREY_W-1:0] r_bin;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bin <= '0;
        end else if (i_clr) begin
            r_bin <= '0;
        end else if (i_step) begin
            r_bin <= i_dir ? (r_bin + 1'b1) : (r_bin - 1'b1);
        end
    end

    assign o_bin = r_bin;
`endif

endmodule : grey_step_ctr
`default_nettype wire

// File: rtl/grey_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : grey_clk_div
// Description : Programmable clock-enable divider driving an up/down Gray
//               counter. A binary prescaler emits a one-cycle tick every
//               (div_reg+1) enabled cycles; each tick steps the Gray code.
//               clk  : sole clock
//               rst  : synchronous, active-low reset
//               bus  : grey_clk_div_if.slave (en, div_ld, div_val, dir, clr
//                      in; tick, grey, wrap out)
//               Optional macro GREY_CLK_DIV_BIN_OUT_EN adds bus.bin, the
//               registered binary count.
//               Priority after reset: clr, then div_ld, then en.
// Revision    : 1.0 - initial release
// ============================================================================
module grey_clk_div
    import grey_clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int GREY_W  = 6,
    parameter int DIV_RST = 15
) (
    input  wire logic       clk,
    input  wire logic       rst,
    grey_clk_div_if.slave   bus
);

    localparam logic [DIV_W-1:0] c_DIV_RST = DIV_W'(DIV_RST);

    generate
        if (GREY_W < c_GREY_W_MIN || GREY_W > c_FN_W) begin : g_bad_grey_w
            $error("grey_clk_div: GREY_W out of range");
        end
        if (DIV_W < 31 && (DIV_RST < 0 || DIV_RST >= (1 << DIV_W))) begin : g_bad_div_rst
            $error("grey_clk_div: DIV_RST does not fit in DIV_W bits");
        end
    endgenerate

    logic [DIV_W-1:0]  r_presc;
    logic [DIV_W-1:0]  r_div_reg;
    logic              r_tick;
    logic              w_step;
    logic [GREY_W-1:0] w_grey;
    logic              w_wrap;

    // Prescaler and divisor register. clr and div_ld both restart the
    // prescaler and kill a pending terminal count; only div_ld touches
    // the divisor, so a clr+div_ld pair still loads the new ratio.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc   <= '0;
            r_div_reg <= c_DIV_RST;
            r_tick    <= 1'b0;
        end else begin
            if (bus.div_ld) begin
                r_div_reg <= bus.div_val;
            end
            if (bus.clr || bus.div_ld) begin
                r_presc <= '0;
                r_tick  <= 1'b0;
            end else if (bus.en) begin
                if (r_presc == r_div_reg) begin
                    r_presc <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                    r_tick  <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    // The Gray counter consumes the registered tick, so grey moves one
    // cycle after tick is seen high. A clear in that cycle wins.
    assign w_step = r_tick & ~bus.clr;

    grey_step_ctr #(
        .GREY_W (GREY_W)
    ) u_step_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_step (w_step),
        .i_dir  (bus.dir),
        .i_clr  (bus.clr),
`ifdef GREY_CLK_DIV_BIN_OUT_EN
        .o_bin  (bus.bin),
`endif
        .o_grey (w_grey),
        .o_wrap (w_wrap)
    );

    assign bus.tick = r_tick;
    assign bus.grey = w_grey;
    assign bus.wrap = w_wrap;

endmodule : grey_clk_div
`default_nettype wire

// File: tb/tb_grey_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_grey_clk_div
// Description : Self-checking bench for grey_clk_div (DIV_W=8, GREY_W=6,
//               DIV_RST=15). A directed vector table followed by hand-written
//               multi-cycle sequences. Honours GREY_CLK_DIV_BIN_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grey_clk_div;

    localparam int DIV_W   = 8;
    localparam int GREY_W  = 6;
    localparam int DIV_RST = 15;

    typedef struct {
        logic             rst_n;
        logic             en;
        logic             div_ld;
        logic [DIV_W-1:0] div_val;
        logic             dir;
        logic             clr;
        logic             e_tick;
        logic [GREY_W-1:0] e_grey;
        logic             e_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    grey_clk_div_if #(.DIV_W(DIV_W), .GREY_W(GREY_W)) bus ();

    grey_clk_div #(
        .DIV_W   (DIV_W),
        .GREY_W  (GREY_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [GREY_W-1:0] g_of(input int n);
        logic [GREY_W-1:0] v;
        v = GREY_W'(n);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [GREY_W-1:0] tb_g2b(input logic [GREY_W-1:0] g);
        logic [GREY_W-1:0] b;
        b = '0;
        for (int i = GREY_W - 1; i >= 0; i--) begin
            b[i] = g[i] ^ ((i == GREY_W - 1) ? 1'b0 : b[i+1]);
        end
        return b;
    endfunction

    task automatic check(input string name, input logic e_tick,
                         input logic [GREY_W-1:0] e_grey, input logic e_wrap);
        logic ok;
`ifdef GREY_CLK_DIV_BIN_OUT_EN
        logic [GREY_W-1:0] e_bin;
        e_bin = tb_g2b(e_grey);
`endif
        n_vec++;
        ok = (bus.tick === e_tick) && (bus.grey === e_grey) && (bus.wrap === e_wrap);
`ifdef GREY_CLK_DIV_BIN_OUT_EN
        ok = ok && (bus.bin === e_bin);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got tick=%b grey=%b wrap=%b bin=%b, want tick=%b grey=%b wrap=%b bin=%b",
                     name, bus.tick, bus.grey, bus.wrap, bus.bin, e_tick, e_grey, e_wrap, e_bin);
        end
`else
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got tick=%b grey=%b wrap=%b, want tick=%b grey=%b wrap=%b",
                     name, bus.tick, bus.grey, bus.wrap, e_tick, e_grey, e_wrap);
        end
`endif
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic ld, input logic [DIV_W-1:0] val,
                         input logic dir, input logic clr);
        bus.en      = en;
        bus.div_ld  = ld;
        bus.div_val = val;
        bus.dir     = dir;
        bus.clr     = clr;
    endtask

    task automatic do_reset(input string name);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc();
        check(name, 1'b0, '0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[19];
        logic [GREY_W-1:0] prev_g;
        int wraps;

        //          rst en ld val dir clr | tick grey       wrap
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 6'd0,  1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd1,  1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 6'd1,  1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd3,  1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd3,  1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 6'd3,  1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd1,  1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd1,  1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd0,  1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd32, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 6'd0,  1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 6'd1,  1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // ---- table: div=1, up/down, en gap, down-wrap, clear ----
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst_n;
            drive(tbl[i].en, tbl[i].div_ld, tbl[i].div_val, tbl[i].dir, tbl[i].clr);
            cyc();
            check($sformatf("table[%0d]", i), tbl[i].e_tick, tbl[i].e_grey, tbl[i].e_wrap);
        end

        // ---- default /16 up run: 64 ticks, single-bit steps, one wrap ----
        do_reset("reset_a");
        bus.en = 1'b1;
        prev_g = '0;
        wraps  = 0;
        for (int c = 1; c <= 1025; c++) begin
            cyc();
            check($sformatf("div16_up c%0d", c), (c % 16) == 0, g_of(((c - 1) / 16) % 64), c == 1025);
            if (bus.wrap === 1'b1) wraps++;
            if (bus.grey !== prev_g) begin
                n_vec++;
                if ($countones(bus.grey ^ prev_g) != 1) begin
                    n_bad++;
                    $display("FAIL one_bit c%0d: got %b after %b, want single-bit change", c, bus.grey, prev_g);
                end
                prev_g = bus.grey;
            end
        end
        n_vec++;
        if (wraps != 1) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d, want 1", wraps);
        end

        // ---- div 0 (tick every cycle), then reload div 4 ----
        do_reset("reset_b");
        drive(1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
        cyc();
        check("ld0", 1'b0, '0, 1'b0);
        bus.div_ld = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check($sformatf("div0 k%0d", k), 1'b1, g_of(k - 1), 1'b0);
        end
        bus.div_ld  = 1'b1;
        bus.div_val = 8'd4;
        cyc();
        check("ld4", 1'b0, g_of(6), 1'b0);
        bus.div_ld = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check($sformatf("div4 k%0d", k), (k % 5) == 0, g_of(k >= 6 ? 7 : 6), 1'b0);
        end

        // ---- count down from reset: wrap to bin 63, then 62 ----
        do_reset("reset_c");
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 33; c++) begin
            cyc();
            if (c == 16) check("down c16", 1'b1, 6'b000000, 1'b0);
            if (c == 17) check("down c17", 1'b0, 6'b100000, 1'b1);
            if (c == 32) check("down c32", 1'b1, 6'b100000, 1'b0);
            if (c == 33) check("down c33", 1'b0, 6'b100001, 1'b0);
        end

        // ---- en low for 7 cycles at presc=9: tick slips 7 cycles ----
        do_reset("reset_d");
        bus.en = 1'b1;
        for (int c = 1; c <= 9; c++) cyc();
        bus.en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            check($sformatf("en_off k%0d", k), 1'b0, '0, 1'b0);
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check($sformatf("en_resume k%0d", k), k == 7, (k == 8) ? g_of(1) : g_of(0), 1'b0);
        end

        // ---- clr + div_ld together at terminal count ----
        do_reset("reset_e");
        bus.en = 1'b1;
        for (int c = 1; c <= 15; c++) cyc();
        drive(1'b1, 1'b1, 8'd3, 1'b1, 1'b1);
        cyc();
        check("clr_ld", 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("div3 k%0d", k), (k % 4) == 0, g_of((k - 1) / 4), 1'b0);
        end

        // ---- reset pulse mid-run ----
        do_reset("reset_f");
        bus.en = 1'b1;
        for (int c = 1; c <= 40; c++) cyc();
        check("pre_rst", 1'b0, g_of(2), 1'b0);
        rst = 1'b0;
        cyc();
        check("mid_rst", 1'b0, '0, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check($sformatf("post_rst k%0d", k), k == 16, '0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_grey_clk_div
`default_nettype wire
